// File: rtl/vector_reverse_pkg.sv
// Shared mode encodings and reorder index mapping
// for the vector reverse stream block.
package vector_reverse_pkg;

    localparam logic [1:0] MODE_PASS      = 2'b00;
    localparam logic [1:0] MODE_BITREV    = 2'b01;
    localparam logic [1:0] MODE_BYTEREV   = 2'b10;
    localparam logic [1:0] MODE_BITINBYTE = 2'b11;

    // Source bit index feeding output bit i of a width-bit word.
    function automatic int unsigned reorder_src(
        input int unsigned i,
        input logic [1:0]  mode,
        input int unsigned width
    );
        reorder_src = i;
        unique case (mode)
            MODE_PASS:      reorder_src = i;
            MODE_BITREV:    reorder_src = width - 1 - i;
            MODE_BYTEREV:   reorder_src = (width / 8 - 1 - i / 8) * 8 + i % 8;
            MODE_BITINBYTE: reorder_src = (i / 8) * 8 + 7 - i % 8;
            default:        reorder_src = i;
        endcase
    endfunction

endpackage

// File: rtl/vector_reverse_stream_skid_buffer.sv
// Two-entry valid/ready register slice: output register
// plus one skid entry, with a registered in_ready.
module stream_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             accept;
    logic             load;

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign load     = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (load) begin
            // A held skid word always leaves first to keep FIFO order.
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_data <= in_data;
                end
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/vector_reverse_stream.sv
// Streaming word reorder (pass / bit rev / byte rev / bit-in-byte)
// behind a skid buffer, with an output transfer counter.
module vector_reverse_stream
    import vector_reverse_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_vector,
    input  logic [1:0]       in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_vector,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_count,
    output logic [CNT_W-1:0] out_count
);

    localparam int IDX_W = $clog2(WIDTH);

    generate
        if (WIDTH < 8 || WIDTH % 8 != 0) begin : g_bad_width
            $error("vector_reverse_stream: WIDTH must be a multiple of 8, >= 8");
        end
    endgenerate

    logic [WIDTH-1:0] mapped;

    for (genvar g = 0; g < WIDTH; g++) begin : g_map
        assign mapped[g] = in_vector[IDX_W'(reorder_src(g, in_mode, WIDTH))];
    end

    stream_skid_buffer #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (mapped),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_vector),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (clr_count) begin
            out_count <= '0;
        end else if (out_valid && out_ready) begin
            out_count <= out_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_vector_reverse_stream.sv
// Scoreboard bench for vector_reverse_stream: a 16-bit instance
// with a 4-bit counter and an 8-bit instance with the default counter.
module tb_vector_reverse_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [15:0] in_vector16;
    logic [1:0]  in_mode16;
    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] out_vector16;
    logic        out_valid16;
    logic        out_ready16;
    logic        clr16;
    logic [3:0]  count16;

    logic [7:0]  in_vector8;
    logic [1:0]  in_mode8;
    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  out_vector8;
    logic        out_valid8;
    logic        out_ready8;
    logic        clr8;
    logic [15:0] count8;

    int checks = 0;
    int errors = 0;

    logic [15:0] q16[$];
    logic [7:0]  q8[$];

    always #5 clk = ~clk;

    vector_reverse_stream #(.WIDTH(16), .CNT_W(4)) d16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vector  (in_vector16),
        .in_mode    (in_mode16),
        .in_valid   (in_valid16),
        .in_ready   (in_ready16),
        .out_vector (out_vector16),
        .out_valid  (out_valid16),
        .out_ready  (out_ready16),
        .clr_count  (clr16),
        .out_count  (count16)
    );

    vector_reverse_stream #(.WIDTH(8), .CNT_W(16)) d8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vector  (in_vector8),
        .in_mode    (in_mode8),
        .in_valid   (in_valid8),
        .in_ready   (in_ready8),
        .out_vector (out_vector8),
        .out_valid  (out_valid8),
        .out_ready  (out_ready8),
        .clr_count  (clr8),
        .out_count  (count8)
    );

    function automatic logic [15:0] model16(input logic [15:0] v,
                                            input logic [1:0] m);
        logic [15:0] b;
        logic [15:0] y;
        b = {<<{v}};
        y = {<<8{v}};
        case (m)
            2'b00:   return v;
            2'b01:   return b;
            2'b10:   return y;
            default: return {<<8{b}};
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid16 && out_ready16) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL mon16_unexpected: got %h, required no output",
                         out_vector16);
            end else begin
                logic [15:0] e;
                e = q16.pop_front();
                if (out_vector16 !== e) begin
                    errors++;
                    $display("FAIL mon16_data: got %h, required %h",
                             out_vector16, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL mon8_unexpected: got %h, required no output",
                         out_vector8);
            end else begin
                logic [7:0] e;
                e = q8.pop_front();
                if (out_vector8 !== e) begin
                    errors++;
                    $display("FAIL mon8_data: got %h, required %h",
                             out_vector8, e);
                end
            end
        end
    end

    task automatic send16(input logic [15:0] d, input logic [1:0] m,
                          input logic [15:0] e);
        bit done = 0;
        int n = 0;
        in_vector16 = d;
        in_mode16   = m;
        in_valid16  = 1'b1;
        while (!done && n < 200) begin
            @(negedge clk);
            if (in_ready16) begin
                q16.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid16 = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send16_timeout: in_ready stuck low, word %h", d);
        end
    endtask

    task automatic send8(input logic [7:0] d, input logic [1:0] m,
                         input logic [7:0] e);
        bit done = 0;
        int n = 0;
        in_vector8 = d;
        in_mode8   = m;
        in_valid8  = 1'b1;
        while (!done && n < 200) begin
            @(negedge clk);
            if (in_ready8) begin
                q8.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid8 = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send8_timeout: in_ready stuck low, word %h", d);
        end
    endtask

    task automatic drain16();
        int n = 0;
        out_ready16 = 1'b1;
        while (q16.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q16.size() != 0) begin
            errors++;
            $display("FAIL drain16: %0d words left, required 0", q16.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain8();
        int n = 0;
        out_ready8 = 1'b1;
        while (q8.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q8.size() != 0) begin
            errors++;
            $display("FAIL drain8: %0d words left, required 0", q8.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_vector16 = '0; in_mode16 = '0; in_valid16 = 0;
        out_ready16 = 1; clr16 = 0;
        in_vector8 = '0; in_mode8 = '0; in_valid8 = 0;
        out_ready8 = 1; clr8 = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 5;
        if (out_valid16 !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid16: got %b, required 0", out_valid16);
        end
        if (out_vector16 !== 16'h0) begin
            errors++;
            $display("FAIL reset_vector16: got %h, required 0000", out_vector16);
        end
        if (in_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready16: got %b, required 1", in_ready16);
        end
        if (count16 !== 4'h0) begin
            errors++;
            $display("FAIL reset_count16: got %0d, required 0", count16);
        end
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || count8 !== 16'h0) begin
            errors++;
            $display("FAIL reset_d8: got v=%b r=%b c=%0d, required 0 1 0",
                     out_valid8, in_ready8, count8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_modes16();
        logic [15:0] exp_v [4];
        exp_v = '{16'h1234, 16'h2C48, 16'h3412, 16'h482C};
        out_ready16 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send16(16'h1234, 2'(k), exp_v[k]);
            checks++;
            if (out_valid16 !== 1'b1 || out_vector16 !== exp_v[k]) begin
                errors++;
                $display("FAIL modes16_latency%0d: got v=%b %h, required 1 %h",
                         k, out_valid16, out_vector16, exp_v[k]);
            end
        end
        drain16();
        checks++;
        if (count16 !== 4'd4) begin
            errors++;
            $display("FAIL modes16_count: got %0d, required 4", count16);
        end
    endtask

    task automatic test_bitrev8();
        logic [7:0] din [4];
        logic [7:0] dout [4];
        din  = '{8'b01010101, 8'b11110000, 8'b00001111, 8'b11001100};
        dout = '{8'b10101010, 8'b00001111, 8'b11110000, 8'b00110011};
        out_ready8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send8(din[k], 2'b01, dout[k]);
        end
        send8(8'hA5, 2'b10, 8'hA5);
        send8(8'h01, 2'b11, 8'h80);
        drain8();
        checks++;
        if (count8 !== 16'd6) begin
            errors++;
            $display("FAIL bitrev8_count: got %0d, required 6", count8);
        end
    endtask

    task automatic test_backpressure();
        clr16 = 1'b1;
        @(posedge clk);
        #1;
        clr16 = 1'b0;
        out_ready16 = 1'b0;
        send16(16'h0001, 2'b00, 16'h0001);
        send16(16'h0002, 2'b00, 16'h0002);
        in_vector16 = 16'h0003;
        in_mode16   = 2'b00;
        in_valid16  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks += 2;
            if (in_ready16 !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready%0d: got %b, required 0", k, in_ready16);
            end
            if (out_valid16 !== 1'b1 || out_vector16 !== 16'h0001) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b %h, required 1 0001",
                         k, out_valid16, out_vector16);
            end
            @(posedge clk);
            #1;
        end
        out_ready16 = 1'b1;
        send16(16'h0003, 2'b00, 16'h0003);
        send16(16'h0004, 2'b00, 16'h0004);
        send16(16'h0005, 2'b00, 16'h0005);
        drain16();
        checks++;
        if (count16 !== 4'd5) begin
            errors++;
            $display("FAIL bp_count: got %0d, required 5", count16);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready16 = 1'b0;
        send16(16'hBEEF, 2'b00, 16'hBEEF);
        send16(16'hCAFE, 2'b00, 16'hCAFE);
        checks++;
        if (in_ready16 !== 1'b0 || out_valid16 !== 1'b1) begin
            errors++;
            $display("FAIL mid_full: got r=%b v=%b, required 0 1",
                     in_ready16, out_valid16);
        end
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if (out_valid16 !== 1'b0 || out_vector16 !== 16'h0) begin
            errors++;
            $display("FAIL mid_async_out: got v=%b %h, required 0 0000",
                     out_valid16, out_vector16);
        end
        if (in_ready16 !== 1'b1 || count16 !== 4'h0) begin
            errors++;
            $display("FAIL mid_async_ready_count: got r=%b c=%0d, required 1 0",
                     in_ready16, count16);
        end
        q16.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready16 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (out_valid16 !== 1'b0 || count16 !== 4'h0) begin
            errors++;
            $display("FAIL mid_after: got v=%b c=%0d, required 0 0",
                     out_valid16, count16);
        end
    endtask

    task automatic test_count_wrap();
        out_ready16 = 1'b1;
        for (int k = 0; k < 17; k++) begin
            send16(16'(k * 7 + 3), 2'(k), model16(16'(k * 7 + 3), 2'(k)));
        end
        drain16();
        checks++;
        if (count16 !== 4'd1) begin
            errors++;
            $display("FAIL wrap_count: got %0d, required 1", count16);
        end
        send16(16'h8001, 2'b01, 16'h8001);
        clr16 = 1'b1;
        @(posedge clk);
        #1;
        clr16 = 1'b0;
        checks++;
        if (count16 !== 4'd0 || q16.size() != 0) begin
            errors++;
            $display("FAIL clr_priority: got c=%0d q=%0d, required 0 0",
                     count16, q16.size());
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int cyc = 0;
        bit acc;
        in_valid16 = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            out_ready16 = ($urandom_range(0, 3) != 0);
            if (!in_valid16 && $urandom_range(0, 3) != 0) begin
                in_valid16  = 1'b1;
                in_vector16 = 16'($urandom);
                in_mode16   = 2'($urandom);
            end else if (!in_valid16) begin
                in_vector16 = 16'($urandom);
                in_mode16   = 2'($urandom);
            end
            acc = 0;
            @(negedge clk);
            if (in_valid16 && in_ready16) begin
                q16.push_back(model16(in_vector16, in_mode16));
                sent++;
                acc = 1;
            end
            @(posedge clk);
            #1;
            if (acc) in_valid16 = 1'b0;
            cyc++;
        end
        in_valid16 = 1'b0;
        checks++;
        if (sent != 1000) begin
            errors++;
            $display("FAIL random_sent: got %0d, required 1000", sent);
        end
        drain16();
    endtask

    initial begin
        test_reset();
        test_modes16();
        test_bitrev8();
        test_backpressure();
        test_reset_midstream();
        test_count_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_reverse_stream.md
Name: vector_reverse_stream

Overview:
Parametrised, pipelined successor to the team's fixed 8-bit combinational vector reverser. It accepts WIDTH-bit words on a valid/ready stream and applies a per-word selectable reorder: pass, full bit reverse, byte reverse, or bit reverse within each byte. A 2-entry skid buffer provides full throughput under backpressure, and a wrapping counter records completed output transfers. It sits between stream producers and consumers wherever endianness or bit-order conversion is needed.

Parameters:
WIDTH, 8, data width in bits; must be a multiple of 8 and at least 8; any other value fails at elaboration.
CNT_W, 16, width of the output transfer counter.

Ports:
clk  input  1  clock; all logic is rising-edge triggered.
rst_n  input  1  asynchronous active-low reset.
in_vector  input  WIDTH  input data word.
in_mode  input  2  reorder mode, sampled together with in_vector on acceptance.
in_valid  input  1  input word is valid.
in_ready  output  1  block can accept an input word.
out_vector  output  WIDTH  reordered data word.
out_valid  output  1  out_vector is valid.
out_ready  input  1  downstream accepts the output word.
clr_count  input  1  synchronous clear of out_count.
out_count  output  CNT_W  number of completed output handshakes, modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_vector=0, skid entry empty, in_ready=1, out_count=0. Any word in flight is dropped.
- Modes (combinational reorder applied before registering):
  - 00 pass: out = in.
  - 01 bit reverse: out[i] = in[WIDTH-1-i].
  - 10 byte reverse: byte k of out = byte (WIDTH/8-1-k) of in.
  - 11 bit reverse within each byte; byte positions are unchanged.
  - When WIDTH=8, mode 10 equals pass and mode 11 equals mode 01.
- Input handshake: a word is accepted when in_valid && in_ready. in_ready = !skid_valid and is registered (no combinational path from out_ready).
- Output stage and skid buffer:
  - The output register loads when it is empty or out_ready=1.
  - Load source is the skid entry if occupied, otherwise the accepted input word.
  - If the output register is full, out_ready=0 and an input word is accepted, that word goes to the skid entry.
  - When the skid entry drains into the output register, a simultaneously presented input word is not accepted, because in_ready=0 that cycle.
- Latency: 1 cycle from acceptance to out_valid with an empty pipe. Throughput: 1 word per cycle while out_ready=1.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Outputs out_vector and out_valid hold stable while out_valid=1 and out_ready=0.
- The mode travels with its data word. Changing in_mode never affects words already accepted.
- out_count:
  - Increments on every out_valid && out_ready cycle and wraps from 2^CNT_W-1 to 0.
  - clr_count sets it to 0 on the next edge; clr_count has priority over a simultaneous increment, giving 0.
- The input side ignores X on in_vector and in_mode when in_valid=0.

Decomposition:
- Shared package vector_reverse_pkg: mode localparams MODE_PASS=2'b00, MODE_BITREV=2'b01, MODE_BYTEREV=2'b10, MODE_BITINBYTE=2'b11, plus a reorder function parametrised on WIDTH.
- One sub-module: stream_skid_buffer (WIDTH-parametrised 2-entry valid/ready register slice), reusable elsewhere. The top contains the reorder function, the skid instance and the counter.

Test Plan:
- WIDTH=16, out_ready=1; send 16'h1234 in modes 00, 01, 10, 11 on consecutive cycles -> out_vector 16'h1234, 16'h2C48, 16'h3412, 16'h482C on consecutive cycles, each 1 cycle after acceptance; out_count=4.
- WIDTH=8; send 8'b01010101, 8'b11110000, 8'b00001111, 8'b11001100 in mode 01 -> 8'b10101010, 8'b00001111, 8'b11110000, 8'b00110011.
- Backpressure: stream 16'h0001..16'h0005 (mode 00) with out_ready=0 for 3 cycles -> in_ready drops after 2 words are held; out_vector stable at 16'h0001; after out_ready=1 all 5 words arrive in order with no loss.
- Assert rst_n low mid-stream with out_valid=1 and skid full -> out_valid=0, out_vector=0, out_count=0 and in_ready=1 immediately (asynchronous); the old words never appear after release.
- CNT_W=4: perform 17 transfers -> out_count=1. Assert clr_count in the same cycle as a handshake -> out_count=0.
- Randomised out_ready and in_valid, 1000 words with random modes -> output matches the reference reorder model in order.
